// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared types and constants for the UART instruction-memory
//                loader: frame FSM states, receiver states and sync byte.
//  Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    // Frame-level states of the loader
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DATA  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_e;

    // Bit-level states of the serial receiver
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/imem_uart_loader_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver with 2-flop synchronizer, mid-start-bit
//                glitch rejection and stop-bit framing check.
//  Ports       : clk      - system clock
//                reset    - synchronous active-low reset
//                rxd      - asynchronous serial input (idle high)
//                rx_byte  - last received byte
//                rx_valid - 1-cycle pulse, byte received with good stop bit
//                rx_ferr  - 1-cycle pulse, stop bit sampled low
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);

    // sync_q[1] is the synchronized line; sync_q[2] is its previous value
    logic [2:0]    sync_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          rxd_s;
    logic          fall;

    assign rxd_s = sync_q[1];
    assign fall  = sync_q[2] & ~sync_q[1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= 3'b111;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], rxd};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (fall) state_d = RX_START;
            end
            RX_START: begin
                // Re-check in the middle of the start bit; high means glitch
                if (cnt_q == CW'(HALF_BIT - 1)) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rxd_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d  = '0;
                    byte_d = {rxd_s, byte_q[7:1]};   // LSB first
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rxd_s) valid_d = 1'b1;
                    else       ferr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_byte  = byte_q;
    assign rx_valid = valid_q;
    assign rx_ferr  = ferr_q;

endmodule
`default_nettype wire

// File: rtl/imem_uart_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_uart_loader
//  Description : Receives a framed program image over UART and writes it
//                word-by-word into instruction memory, holding the CPU
//                while a frame is in progress or after a failed load.
//                Frame: A5, N, 4*N little-endian data bytes, XOR checksum.
//  Ports       : clk, reset (sync active-low), uart_rxd (serial in),
//                imem_we/imem_waddr/imem_wdata (memory write port),
//                cpu_hold, load_busy, load_done, load_error, words_loaded.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_uart_loader
    import loader_pkg::*;
#(
    parameter int CLK_HZ         = 50000000,
    parameter int BAUD           = 115200,
    parameter int DEPTH_WORDS    = 256,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rxd,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_error,
    output logic [8:0]  words_loaded
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .rxd      (uart_rxd),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );

    state_e      state_q, state_d;
    logic [8:0]  n_q, n_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [31:0] asm_q, asm_d;
    logic [7:0]  csum_q, csum_d;
    logic [31:0] tmo_q, tmo_d;
    logic        we_q, we_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [8:0]  words_q, words_d;
    logic        busy;

    assign busy = (state_q == COUNT) || (state_q == DATA) || (state_q == CHECK);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            bidx_q  <= '0;
            asm_q   <= '0;
            csum_q  <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            bidx_q  <= bidx_d;
            asm_q   <= asm_d;
            csum_q  <= csum_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
            words_q <= words_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        bidx_d  = bidx_q;
        asm_d   = asm_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        words_d = words_q;

        // Inter-byte idle counter: reloads on every byte, runs only in a frame
        if (busy) tmo_d = rx_valid ? 32'd0 : tmo_q + 32'd1;
        else      tmo_d = 32'd0;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    words_d = '0;
                    csum_d  = '0;
                    hold_d  = 1'b1;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (rx_valid) begin
                    n_d = {1'b0, rx_byte};
                    if (rx_byte == 8'd0 || 32'(rx_byte) > DEPTH_WORDS) begin
                        state_d = ERROR;
                    end else begin
                        bidx_d  = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    csum_d = csum_q ^ rx_byte;
                    asm_d[{bidx_q, 3'b000} +: 8] = rx_byte;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        // Registered, so the strobe lands 1 cycle after rx_valid
                        we_d    = 1'b1;
                        waddr_d = {21'd0, words_q, 2'b00};
                        wdata_d = {rx_byte, asm_q[23:0]};
                        words_d = words_q + 9'd1;
                        if (words_q + 9'd1 == n_q) state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (rx_valid) state_d = (rx_byte == csum_q) ? DONE : ERROR;
            end
            default: state_d = IDLE;
        endcase

        // Abort conditions; a byte arriving on the timeout cycle wins
        if (busy && !rx_valid &&
            (rx_ferr || tmo_q >= 32'(TIMEOUT_CYCLES - 1))) begin
            state_d = ERROR;
        end

        if (state_d == DONE && state_q != DONE) begin
            done_d = 1'b1;
            hold_d = 1'b0;
        end
        // Memory may be partially written, so hold stays asserted on error
        if (state_d == ERROR && state_q != ERROR) begin
            err_d = 1'b1;
        end
    end

    assign imem_we      = we_q;
    assign imem_waddr   = waddr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_hold     = hold_q;
    assign load_busy    = busy;
    assign load_done    = done_q;
    assign load_error   = err_q;
    assign words_loaded = words_q;

endmodule
`default_nettype wire
